// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide engine.
package hilo_muldiv_unit_pkg;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic op_is_div(input op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input op_e op);
      return ~op[0];
   endfunction
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide engine.
interface hilo_muldiv_unit_if;
   import hilo_muldiv_unit_pkg::*;

   logic             start;
   op_e              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi_out, lo_out, div_by_zero
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi_out, lo_out, div_by_zero
   );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_sign_fix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res_c
);
   assign res_c = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine producing {HI,LO}; one bit per cycle on
// magnitudes, with a sign fix-up cycle before completion.
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   hilo_muldiv_unit_if.slave bus
);
   localparam int unsigned PW = 2 * WIDTH;

   state_e             state_q, state_n;
   logic               accept;
   logic               busy_q, done_q, dbz_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [PW-1:0]      p_q, p_step;
   logic [WIDTH-1:0]   opnd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               is_div_q, sa_q, sb_q;

   logic               in_div, in_signed, neg_a, neg_b, div_zero;
   logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
   logic [PW-1:0]      prod_fix;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;

   assign in_div    = op_is_div(bus.op);
   assign in_signed = op_is_signed(bus.op);
   assign neg_a     = in_signed & bus.a[WIDTH-1];
   assign neg_b     = in_signed & bus.b[WIDTH-1];
   assign div_zero  = in_div && (bus.b == '0);

   muldiv_sign_fix #(.W(WIDTH)) u_abs_a    (.val(bus.a),            .neg(neg_a),       .res_c(abs_a));
   muldiv_sign_fix #(.W(WIDTH)) u_abs_b    (.val(bus.b),            .neg(neg_b),       .res_c(abs_b));
   muldiv_sign_fix #(.W(PW))    u_fix_prod (.val(p_q),              .neg(sa_q ^ sb_q), .res_c(prod_fix));
   muldiv_sign_fix #(.W(WIDTH)) u_fix_quo  (.val(p_q[WIDTH-1:0]),   .neg(sa_q ^ sb_q), .res_c(quo_fix));
   muldiv_sign_fix #(.W(WIDTH)) u_fix_rem  (.val(p_q[PW-1:WIDTH]),  .neg(sa_q),        .res_c(rem_fix));

   // Next state; Flush overrides everything, including a same-cycle Start.
   always_comb begin
      state_n = state_q;
      accept  = 1'b0;
      if (bus.flush) begin
         state_n = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  accept  = 1'b1;
                  state_n = div_zero ? ST_DONE : ST_RUN;
               end else begin
                  state_n = ST_IDLE;
               end
            end
            ST_RUN:   if (cnt_q == CNT_W'(WIDTH - 1)) state_n = ST_FIXUP;
            ST_FIXUP: state_n = ST_DONE;
            default:  state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         busy_q  <= (state_n == ST_RUN) || (state_n == ST_FIXUP);
         done_q  <= (state_n == ST_DONE);
      end
   end

   // Shared 64-bit work register: {acc, multiplier} for multiply, {remainder, quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{p_q[0]}}};
      div_shift = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (is_div_q) begin
         p_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};
      end else begin
         p_step = {mul_sum, p_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         p_q      <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else if (accept) begin
         is_div_q <= in_div;
         sa_q     <= neg_a;
         sb_q     <= neg_b;
         opnd_q   <= in_div ? abs_b : abs_a;
         p_q      <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
         cnt_q    <= '0;
         dbz_q    <= div_zero;
         if (div_zero) begin
            hi_q <= bus.a;
            lo_q <= '1;
         end
      end else if (state_q == ST_RUN) begin
         p_q   <= p_step;
         cnt_q <= cnt_q + CNT_W'(1);
      end else if ((state_q == ST_FIXUP) && !bus.flush) begin
         if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
         end else begin
            hi_q <= prod_fix[PW-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hi_out      = hi_q;
   assign bus.lo_out      = lo_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   logic Clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   hilo_muldiv_unit_if bus ();

   hilo_muldiv_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: MIPS semantics computed with wide plain arithmetic.
   task automatic ref_model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
      logic signed [63:0] sa, sb, sp, sq, sr;
      logic        [63:0] ua, ub, up;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      dbz = 1'b0;
      case (op)
         OP_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
         OP_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
         default: begin
            if (b == 32'h0) begin
               hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
            end else if (op == OP_DIV) begin
               sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0];
            end else begin
               up = ua / ub; hi = 32'(ua % ub); lo = up[31:0];
            end
         end
      endcase
   endtask

   // Launch one op (start sampled at "edge 0"), then watch Busy/Done cycle by cycle.
   task automatic do_op(input op_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] ehi, elo;
      logic        edbz;
      int          busy_n, done_edge;
      ref_model(op, a, b, ehi, elo, edbz);
      @(negedge Clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge Clk); #1;
      bus.start = 1'b0;
      busy_n = 0; done_edge = -1;
      for (int e = 0; e < 100; e++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin done_edge = e; break; end
         @(posedge Clk); #1;
      end
      chk({tag, " done_edge"}, 64'(done_edge), edbz ? 64'd0 : 64'd33);
      chk({tag, " busy_cycles"}, 64'(busy_n), edbz ? 64'd0 : 64'd33);
      chk({tag, " hi"}, 64'(bus.hi_out), 64'(ehi));
      chk({tag, " lo"}, 64'(bus.lo_out), 64'(elo));
      chk({tag, " dbz"}, 64'(bus.div_by_zero), 64'(edbz));
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge Clk); #1;
      chk({tag, " done_pulse_low"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      logic [31:0] hold_hi, hold_lo;
      op_e         rop;
      logic [31:0] ra, rb;

      bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst done", 64'(bus.done), 64'd0);
      chk("rst hi", 64'(bus.hi_out), 64'd0);
      chk("rst lo", 64'(bus.lo_out), 64'd0);
      chk("rst dbz", 64'(bus.div_by_zero), 64'd0);
      @(negedge Clk) Reset = 1'b0;

      do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      idle_cycle("multu_max");
      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
      do_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      idle_cycle("div_ovf");
      do_op(OP_DIVU, 32'd5, 32'd0, "divu_by0");
      do_op(OP_MULTU, 32'd2, 32'd3, "multu_2x3");
      idle_cycle("multu_2x3");

      // Flush mid-operation: no Done, previous result held.
      hold_hi = bus.hi_out; hold_lo = bus.lo_out;
      @(negedge Clk);
      bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
      @(posedge Clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge Clk);
      #1;
      chk("flush busy_before", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(posedge Clk); #1;
      bus.flush = 1'b0;
      chk("flush busy_after", 64'(bus.busy), 64'd0);
      begin
         int seen_done = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (bus.done || bus.busy) seen_done++;
         end
         chk("flush no_done", 64'(seen_done), 64'd0);
      end
      chk("flush hi_hold", 64'(bus.hi_out), 64'(hold_hi));
      chk("flush lo_hold", 64'(bus.lo_out), 64'(hold_lo));

      // Flush and Start together in IDLE: nothing starts.
      @(negedge Clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MULTU; bus.a = 32'd9; bus.b = 32'd9;
      @(posedge Clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_start busy", 64'(bus.busy), 64'd0);
      repeat (3) @(posedge Clk);
      #1;
      chk("flush_start still_idle", 64'(bus.busy | bus.done), 64'd0);

      // Asynchronous reset in the middle of RUN.
      @(negedge Clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
      @(posedge Clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("midrst busy", 64'(bus.busy), 64'd0);
      chk("midrst done", 64'(bus.done), 64'd0);
      chk("midrst hi", 64'(bus.hi_out), 64'd0);
      chk("midrst lo", 64'(bus.lo_out), 64'd0);
      @(negedge Clk) Reset = 1'b0;
      do_op(OP_DIVU, 32'd1000, 32'd3, "after_rst");

      // Randomized operations, mixing in zero divisors and edge operands.
      for (int n = 0; n < 24; n++) begin
         rop = op_e'(2'($urandom_range(0, 3)));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'(($urandom_range(0, 15)));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         do_op(rop, ra, rb, $sformatf("rand%0d", n));
         if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
